tick_period_meter: RTL and testbench
====================================

Name: tick_period_meter

Overview:
- Measures the period and high time of a slow, divided clock or tick signal (e.g. a divider output or an external square wave) in system clock cycles.
- Used on the FPGA board to verify divider settings and feed the display and debug paths.
- Converts a generated frequency back into a count.
- One-shot by default: software/FSM issues `start`, block reports one result or a timeout.

Parameters:
- CNT_W, 32, width of the period/high-time counters and outputs.
- TIMEOUT, 100_000_000, clk cycles allowed while waiting for an edge (either phase) before aborting.
- SYNC_STAGES, 2, flip-flops in the input synchronizer (minimum 2).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- sig_in  input  1  measured signal, asynchronous to clk.
- start  input  1  single-cycle request to begin a measurement; ignored unless idle.
- busy  output  1  high while a measurement is in progress.
- period  output  CNT_W  clk cycles between two consecutive rising edges; held until next valid.
- high_time  output  CNT_W  clk cycles the synchronized signal was high within that period.
- valid  output  1  one-cycle pulse: period/high_time updated.
- timeout  output  1  one-cycle pulse: measurement aborted.
- rise_pulse  output  1  one-cycle pulse per synchronized rising edge, always active (debug/tick use).

Behaviour:
- Reset is asynchronous and active-low, one clock.
- Reset values: busy=0, period=0, high_time=0, valid=0, timeout=0, rise_pulse=0, synchronizer and edge register=0, FSM=IDLE.
- Reset asserted mid-measurement aborts it immediately. No valid or timeout is emitted.
- Synchronizer: sig_in passes through SYNC_STAGES flops giving `s`. Edge register `s_d` gives rise = s & ~s_d.
- rise_pulse is registered: high the cycle after rise. Total latency from sig_in rising to rise_pulse is SYNC_STAGES+1 cycles.
- Edge mask: rises detected during the first SYNC_STAGES+1 cycles after rst_n deasserts are suppressed. This applies to both rise_pulse and the FSM.
- FSM states:
  - IDLE: busy=0. start → WAIT_EDGE; the wait counter is cleared to 0.
  - WAIT_EDGE: busy=1. The wait counter increments each cycle.
    - On rise (cycle E1) → MEASURE with cnt=1; hcnt=1 (s is high at E1).
    - If the wait counter reaches TIMEOUT-1 with no rise → IDLE with timeout pulse next cycle.
  - MEASURE: busy=1. Each non-rise cycle: cnt+=1, and hcnt+=1 if s=1.
    - On rise (cycle E2): period<=cnt, high_time<=hcnt, valid=1 next cycle, → IDLE. Hence period = E2−E1 exactly.
    - If cnt reaches TIMEOUT with no rise → IDLE, timeout pulse, period/high_time unchanged.
- start in the same cycle as a rise while IDLE: that rise is not used. The first counted edge must occur in WAIT_EDGE.
- start while busy: ignored, no effect on counters.
- valid and timeout are mutually exclusive and never both high.
- Counters never wrap: TIMEOUT must be < 2^CNT_W; implementation saturates at all-ones as protection.
- A signal stuck high or stuck low both end in timeout. Period-complete requires two rises.

Optional Feature:
- Macro MEAS_CONT_EN.
- Defined: continuous mode. After a valid, the FSM stays in MEASURE. The E2 cycle becomes the new E1 (cnt=1, hcnt=1), so a result is produced every period without re-issuing start. busy stays 1. A timeout returns to IDLE. start while IDLE restarts the sequence.
- Undefined: one-shot behaviour as above.

Test Plan:
- Reset release with sig_in already high, then start → no spurious rise; the first counted edge is the next genuine rising edge.
- sig_in from a same-clock divider toggling every 5 cycles (period 10) → valid once with period=10, high_time=5; busy falls the cycle valid rises.
- Duty test: sig_in high 3, low 9 cycles → period=12, high_time=3.
- sig_in held low after start, TIMEOUT=50 → timeout pulse exactly 50 cycles after WAIT_EDGE entry; period keeps its previous value; no valid.
- Second start pulsed mid-MEASURE, then rst_n pulsed low mid-MEASURE → start has no effect; reset clears all outputs within the reset window; no valid or timeout afterwards until the next start.
- MEAS_CONT_EN defined, period-10 input for 5 periods → 5 valid pulses spaced 10 cycles apart, each with period=10, busy constantly 1.

Source files
------------

// File: rtl/tick_period_meter.sv
// tick_period_meter: measures the period and high time of a slow tick or
// square wave, in clk cycles. sig_in is asynchronous to clk and is
// synchronized here.
//
// Build option: define MEAS_CONT_EN for continuous mode. In that mode the
// FSM stays in MEASURE after each result and reports every period until a
// timeout. Without the macro the block is one-shot: one start gives one
// result or one timeout.
//
// Protocol: start is a one-cycle request and is accepted only while busy is
// low. valid and timeout are one-cycle pulses and never both high. period
// and high_time change only in the cycle where valid is high, and then hold.
// There is no back-pressure, so a result pulse must be captured in the cycle
// it appears.
module tick_period_meter #(
    parameter int CNT_W       = 32,
    parameter int TIMEOUT     = 100_000_000,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sig_in,
    input  logic             start,
    output logic             busy,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             valid,
    output logic             timeout,
    output logic             rise_pulse,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_MEAS = 2'd2
    } state_e;

    // A rise seen inside this many cycles after reset comes from the
    // synchronizer filling up, not from a real edge on sig_in.
    localparam int MASK_LEN = SYNC_STAGES + 1;
    localparam int MASK_W   = $clog2(MASK_LEN + 1);

    localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] TO_M1  = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic                   s_d_q;
    logic [MASK_W-1:0]      mask_cnt_q;
    logic                   mask_done;
    logic                   rise;
    logic                   rise_pulse_q;

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       wait_q, wait_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0]       hcnt_q, hcnt_d;
    logic [CNT_W-1:0]       period_q, period_d;
    logic [CNT_W-1:0]       high_q, high_d;
    logic                   valid_q, valid_d;
    logic                   timeout_q, timeout_d;

    // Counters stop at all-ones instead of wrapping. This only matters if
    // TIMEOUT is set too large for CNT_W.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + ONE;
    endfunction

    // Synchronizer chain for sig_in. The last stage is the clean signal s.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    // Edge register, registered rise pulse, and the counter for the reset mask.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_d_q        <= 1'b0;
            rise_pulse_q <= 1'b0;
            mask_cnt_q   <= '0;
        end else begin
            s_d_q        <= s;
            rise_pulse_q <= rise;
            if (!mask_done) begin
                mask_cnt_q <= mask_cnt_q + MASK_W'(1);
            end
        end
    end

    assign mask_done = (mask_cnt_q == MASK_W'(MASK_LEN));
    assign rise      = s & ~s_d_q & mask_done;

    // FSM state, counters and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            wait_q    <= '0;
            cnt_q     <= '0;
            hcnt_q    <= '0;
            period_q  <= '0;
            high_q    <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            cnt_q     <= cnt_d;
            hcnt_q    <= hcnt_d;
            period_q  <= period_d;
            high_q    <= high_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
        end
    end

    // Next-state logic. The cycle of the first rise (E1) counts as cycle 1,
    // so at the closing rise (E2) cnt_q equals E2 - E1.
    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        cnt_d     = cnt_q;
        hcnt_d    = hcnt_q;
        period_d  = period_q;
        high_d    = high_q;
        valid_d   = 1'b0;
        timeout_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // A rise in the same cycle as start is not used. Counting
                // begins with the first rise seen in WAIT.
                if (start) begin
                    state_d = ST_WAIT;
                    wait_d  = '0;
                end
            end
            ST_WAIT: begin
                if (rise) begin
                    state_d = ST_MEAS;
                    cnt_d   = ONE;
                    hcnt_d  = ONE;
                end else if (wait_q >= TO_M1) begin
                    state_d   = ST_IDLE;
                    timeout_d = 1'b1;
                end else begin
                    wait_d = sat_inc(wait_q);
                end
            end
            ST_MEAS: begin
                if (rise) begin
                    period_d = cnt_q;
                    high_d   = hcnt_q;
                    valid_d  = 1'b1;
`ifdef MEAS_CONT_EN
                    // The closing rise also opens the next period.
                    cnt_d    = ONE;
                    hcnt_d   = ONE;
`else
                    state_d  = ST_IDLE;
`endif
                end else if (cnt_q >= TO_VAL) begin
                    state_d   = ST_IDLE;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = sat_inc(cnt_q);
                    if (s) begin
                        hcnt_d = sat_inc(hcnt_q);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy       = (state_q != ST_IDLE);
    assign period     = period_q;
    assign high_time  = high_q;
    assign valid      = valid_q;
    assign timeout    = timeout_q;
    assign rise_pulse = rise_pulse_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_tick_period_meter.sv
// Bench for tick_period_meter. Each waveform is built as a list of
// (high, low) segments. The model finds the rising edges the measurement
// can use and pushes the expected results. The monitor pops and compares
// every valid or timeout the DUT presents.
module tb_tick_period_meter;

    localparam int CNT_W       = 16;
    localparam int TIMEOUT     = 50;
    localparam int SYNC_STAGES = 2;
    localparam int EW          = 1 + 2 * CNT_W;

    logic             clk    = 1'b0;
    logic             rst_n  = 1'b0;
    logic             sig_in = 1'b1;
    logic             start  = 1'b0;
    logic             busy;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic             valid;
    logic             timeout;
    logic             rise_pulse;
    logic [1:0]       dbg_state;

    tick_period_meter #(
        .CNT_W(CNT_W),
        .TIMEOUT(TIMEOUT),
        .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .sig_in(sig_in),
        .start(start),
        .busy(busy),
        .period(period),
        .high_time(high_time),
        .valid(valid),
        .timeout(timeout),
        .rise_pulse(rise_pulse),
        .dbg_state(dbg_state)
    );

    // Clock generation
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int               n_cmp = 0;
    int               n_err = 0;
    logic [EW-1:0]    exp_q[$];
    int               rp_cnt = 0;
    int               gen_rises = 0;
    logic             prev_lv = 1'b1;
    int               model_p = 0;
    int               model_h = 0;
    int               seg_h[$];
    int               seg_l[$];
    logic [EW-1:0]    mon_e;
    logic             last_was_valid = 1'b0;
    int               last_valid_cyc = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every valid or timeout the DUT presents must match the next
    // expected entry in the queue.
    always @(negedge clk) begin
        if (!rst_n) begin
            rp_cnt = 0;
            last_was_valid = 1'b0;
        end else begin
            if (rise_pulse) rp_cnt++;
            if (valid || timeout) begin
                chk("valid_timeout_exclusive", {63'd0, valid && timeout}, 64'd0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_event", {62'd0, valid, timeout}, 64'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("event_is_timeout", {63'd0, timeout}, {63'd0, mon_e[EW-1]});
                    chk("period", {48'd0, period}, {48'd0, mon_e[2*CNT_W-1:CNT_W]});
                    chk("high_time", {48'd0, high_time}, {48'd0, mon_e[CNT_W-1:0]});
                    if (valid) begin
`ifdef MEAS_CONT_EN
                        chk("busy_at_valid", {63'd0, busy}, 64'd1);
                        if (last_was_valid)
                            chk("valid_spacing", cyc - last_valid_cyc, {48'd0, mon_e[2*CNT_W-1:CNT_W]});
`else
                        chk("busy_at_valid", {63'd0, busy}, 64'd0);
`endif
                    end
                end
                last_was_valid = valid;
                last_valid_cyc = cyc;
            end
        end
    end

    // Driver: apply one cycle of inputs at the negedge.
    task automatic step(input logic lv, input logic st);
        sig_in = lv;
        start  = st;
        if (lv && !prev_lv) gen_rises++;
        prev_lv = lv;
        @(negedge clk);
    endtask

    task automatic push_valid(input int p, input int h);
        exp_q.push_back({1'b0, CNT_W'(p), CNT_W'(h)});
        model_p = p;
        model_h = h;
    endtask

    task automatic push_timeout();
        exp_q.push_back({1'b1, CNT_W'(model_p), CNT_W'(model_h)});
    endtask

    task automatic settle();
        int k;
        k = 0;
        while (busy && k < 300) begin
            step(1'b0, 1'b0);
            k++;
        end
        chk("idle_reached", {63'd0, busy}, 64'd0);
        repeat (5) step(1'b0, 1'b0);
        #1;
        chk("queue_drained", exp_q.size(), 64'd0);
        chk("rise_pulse_count", rp_cnt, gen_rises);
    endtask

    // Build the waveform from seg_h/seg_l, push the expected results, then
    // drive it. s1 is the start step. s2 is a second start (-1 for none)
    // that arrives while busy.
    task automatic run_wave(input int pre, input int s1, input int s2, input int tail);
        logic lv[$];
        int   rt[$];
        int   rh[$];
        int   ut[$];
        int   uh[$];
        for (int i = 0; i < pre; i++) lv.push_back(1'b0);
        foreach (seg_h[k]) begin
            rt.push_back(lv.size());
            rh.push_back(seg_h[k]);
            repeat (seg_h[k]) lv.push_back(1'b1);
            repeat (seg_l[k]) lv.push_back(1'b0);
        end
        repeat (tail) lv.push_back(1'b0);
        // A rise driven at step d reaches the FSM at edge d+SYNC_STAGES+1.
        // The start driven at step s1 is accepted at edge s1+1. Only rises
        // that arrive after that edge are counted.
        foreach (rt[k]) begin
            if (rt[k] + SYNC_STAGES + 1 > s1 + 1) begin
                ut.push_back(rt[k]);
                uh.push_back(rh[k]);
            end
        end
`ifdef MEAS_CONT_EN
        for (int j = 0; j + 1 < ut.size(); j++) push_valid(ut[j+1] - ut[j], uh[j]);
        push_timeout();
`else
        if (ut.size() >= 2) push_valid(ut[1] - ut[0], uh[0]);
        else push_timeout();
`endif
        foreach (lv[i]) step(lv[i], (i == s1) || (i == s2));
        settle();
    endtask

    task automatic set_segs(input int h, input int l, input int n);
        seg_h.delete();
        seg_l.delete();
        for (int k = 0; k < n; k++) begin
            seg_h.push_back(h);
            seg_l.push_back(l);
        end
    endtask

    // Watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k;
        // Reset with sig_in already high.
        repeat (2) @(negedge clk);
        #1;
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_period", {48'd0, period}, 64'd0);
        chk("rst_high_time", {48'd0, high_time}, 64'd0);
        chk("rst_valid", {63'd0, valid}, 64'd0);
        chk("rst_timeout", {63'd0, timeout}, 64'd0);
        chk("rst_rise_pulse", {63'd0, rise_pulse}, 64'd0);
        rst_n = 1'b1;
        repeat (10) step(1'b1, 1'b0);
        #1;
        chk("mask_no_rise_pulse", rp_cnt, 64'd0);

        // The first counted edge is the next genuine rise.
        seg_h = '{6, 6, 3};
        seg_l = '{7, 7, 5};
        run_wave(4, 0, -1, 60);

        // Divider output toggling every 5 cycles.
        set_segs(5, 5, 6);
        run_wave(3, 0, -1, 60);

        // Duty test, with a second start while MEASURE is running.
        set_segs(3, 9, 3);
        run_wave(2, 0, 8, 60);

        // start in the same cycle as a rise: that rise is not used.
        seg_h = '{4, 3, 2};
        seg_l = '{8, 5, 6};
        run_wave(0, 2, -1, 60);

        // Stuck low: timeout exactly TIMEOUT cycles after entering WAIT.
        push_timeout();
        step(1'b0, 1'b1);
        k = 0;
        while (!timeout && k < 200) begin
            step(1'b0, 1'b0);
            k++;
        end
        chk("wait_timeout_latency", k, TIMEOUT);
        settle();

        // Stuck high after one rise: MEASURE times out.
        seg_h = '{70};
        seg_l = '{5};
        run_wave(2, 0, -1, 10);

        // Random shapes.
        for (int it = 0; it < 8; it++) begin
            int nseg;
            int pre;
            int s1;
            seg_h.delete();
            seg_l.delete();
            nseg = $urandom_range(2, 4);
            for (int j = 0; j < nseg; j++) begin
                seg_h.push_back($urandom_range(1, 20));
                seg_l.push_back($urandom_range(1, 20));
            end
            pre = $urandom_range(0, 8);
            s1  = $urandom_range(0, pre + 2);
            run_wave(pre, s1, -1, 60);
        end

        // A second start mid-MEASURE, then reset mid-MEASURE.
        repeat (3) step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        repeat (2) step(1'b0, 1'b0);
        repeat (4) step(1'b1, 1'b0);
        repeat (6) step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        repeat (3) step(1'b0, 1'b0);
        #1;
        chk("busy_mid_measure", {63'd0, busy}, 64'd1);
        rst_n = 1'b0;
        #1;
        model_p = 0;
        model_h = 0;
        chk("midrst_busy", {63'd0, busy}, 64'd0);
        chk("midrst_period", {48'd0, period}, 64'd0);
        chk("midrst_high_time", {48'd0, high_time}, 64'd0);
        chk("midrst_valid", {63'd0, valid}, 64'd0);
        chk("midrst_timeout", {63'd0, timeout}, 64'd0);
        repeat (3) step(1'b0, 1'b0);
        gen_rises = 0;
        rst_n = 1'b1;
        repeat (3) step(1'b0, 1'b0);
        repeat (4) step(1'b1, 1'b0);
        repeat (6) step(1'b0, 1'b0);
        repeat (4) step(1'b1, 1'b0);
        repeat (60) step(1'b0, 1'b0);
        #1;
        chk("post_rst_period", {48'd0, period}, model_p);
        chk("post_rst_busy", {63'd0, busy}, 64'd0);
        chk("post_rst_queue", exp_q.size(), 64'd0);
        chk("post_rst_rise_pulses", rp_cnt, gen_rises);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
